// File: rtl/relu_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// relu_maxpool_2x2
//
// Sits downstream of conv_2d. It takes one feature map as a row-major stream
// of 32-bit signed conv results, applies ReLU, requantises each value to
// 16-bit fixed point and 2x2 / stride-2 max-pools the result. The pooled
// stream is sized to feed image_input_pixel of the next conv_2d.
//
// Parameters
//   IMG_W      input feature-map width  (even, >= 2)
//   IMG_H      input feature-map height (even, >= 2)
//   FRAC_BITS  right shift from accumulator format to 16-bit pixel format
//
// Ports
//   clk                in   rising-edge clock
//   rst_n              in   asynchronous active-low reset
//   conv_output_pixel  in   [31:0] signed conv result
//   conv_output_valid  in   input strobe; bubbles allowed, no backpressure
//   frame_clear        in   synchronous abort back to the start of a frame
//   pool_output_pixel  out  [15:0] pooled pixel (never negative)
//   pool_output_valid  out  one-cycle strobe per pooled pixel
//   pool_row_done      out  with the last pooled pixel of each output row
//   pool_complete      out  with the last pooled pixel of the frame
// ---------------------------------------------------------------------------
module relu_maxpool_2x2 #(
  parameter int IMG_W     = 24,
  parameter int IMG_H     = 24,
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] conv_output_pixel,
  input  logic        conv_output_valid,
  input  logic        frame_clear,
  output logic [15:0] pool_output_pixel,
  output logic        pool_output_valid,
  output logic        pool_row_done,
  output logic        pool_complete
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  // Row parity state: even rows fill the line buffer, odd rows emit output.
  localparam logic [0:0] ST_EVEN = 1'b0;
  localparam logic [0:0] ST_ODD  = 1'b1;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [0:0]       state;
  logic [15:0]      hreg;
  logic [15:0]      linebuf [LB_D];

  logic [31:0]      relu_val;
  logic [31:0]      shifted;
  logic [15:0]      pix_q;
  logic [15:0]      hmax;
  logic [15:0]      pool_max;
  logic [LB_AW-1:0] lb_idx;
  logic             col_last;
  logic             row_last;
  logic             accept;

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // ReLU, requantise and saturate. After ReLU the value is non-negative, so
  // every later max is an unsigned compare.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    relu_val = conv_output_pixel[31] ? 32'd0 : conv_output_pixel;
    shifted  = relu_val >> FRAC_BITS;
    pix_q    = (shifted > 32'd32767) ? 16'h7FFF : shifted[15:0];
  end

  assign accept   = conv_output_valid && !frame_clear;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign lb_idx   = LB_AW'(col >> 1);
  // Horizontal pair max; only meaningful on odd columns.
  assign hmax     = max16(hreg, pix_q);
  assign pool_max = max16(hmax, linebuf[lb_idx]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col               <= '0;
      row               <= '0;
      state             <= ST_EVEN;
      hreg              <= '0;
      pool_output_pixel <= '0;
      pool_output_valid <= 1'b0;
      pool_row_done     <= 1'b0;
      pool_complete     <= 1'b0;
    end else begin
      pool_output_valid <= 1'b0;
      pool_row_done     <= 1'b0;
      pool_complete     <= 1'b0;
      if (frame_clear) begin
        col   <= '0;
        row   <= '0;
        state <= ST_EVEN;
      end else if (conv_output_valid) begin
        if (!col[0]) hreg <= pix_q;
        if (col_last) begin
          col   <= '0;
          row   <= row_last ? '0 : row + 1'b1;
          state <= (state == ST_EVEN) ? ST_ODD : ST_EVEN;
        end else begin
          col <= col + 1'b1;
        end
        // Bottom-right pixel of a window: emit the 2x2 max.
        if (state == ST_ODD && col[0]) begin
          pool_output_pixel <= pool_max;
          pool_output_valid <= 1'b1;
          pool_row_done     <= col_last;
          pool_complete     <= col_last && row_last;
        end
      end
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on an even row
  // before the following odd row reads it, so its power-up contents never
  // reach an output, and leaving the reset off lets it map to RAM.
  always_ff @(posedge clk) begin
    if (accept && state == ST_EVEN && col[0]) linebuf[lb_idx] <= hmax;
  end

endmodule
